pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
Pipeline sequencing controller for the five-stage RV32I core. It sits beside the IF/ID and ID/EX pipeline registers and the PC, and owns these controls: PC write enable, IF/ID hold and flush, ID/EX bubble insertion, and the PC redirect select. It resolves load-use stalls and taken branch/jal redirects. It detects the halt instruction (beq x0,x0,0 = 32'h00000063), drains the pipeline, then freezes the core. It also keeps cycle, stall and flush performance counters.

Parameters:
CNT_W, 32, width of each performance counter
DRAIN_CYCLES, 3, cycles allowed after halt decode for older instructions to leave EX/MEM/WB
HALT_INSTR, 32'h00000063, encoding treated as halt when seen in ID

Ports:
CLK  in  1  core clock; all state updates on rising edge
Reset  in  1  synchronous, active-high reset
id_instr  in  32  instruction currently in ID (IF/ID register output)
id_rs1  in  5  rs1 field of ID instruction
id_rs2  in  5  rs2 field of ID instruction
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_mem_read  in  1  instruction in EX is a load
ex_rd  in  5  destination register of EX instruction
ex_redirect  in  1  EX resolved a taken branch or jal/jalr
pc_we  out  1  PC register write enable
pc_sel  out  1  1 = PC loads EX redirect target; 0 = PC+4
ifid_we  out  1  IF/ID register write enable
ifid_flush  out  1  IF/ID loads NOP (32'h00000013)
idex_flush  out  1  ID/EX loads bubble (all control zero)
halted  out  1  core frozen; sticky until Reset
cycle_cnt  out  CNT_W  cycles since reset, excluding HALTED
stall_cnt  out  CNT_W  load-use stall cycles
flush_cnt  out  CNT_W  redirect cycles

Behaviour:
- State machine: RUN, DRAIN, HALTED. Registers: state, drain counter (width clog2(DRAIN_CYCLES+1)), halted, three counters.
- Control outputs are combinational from state and inputs, so they act in the same cycle.
- Reset = 1 (sampled at edge): state <= RUN, drain <= 0, halted <= 0, all counters <= 0.
- While Reset = 1, combinational outputs are: pc_we=0, pc_sel=0, ifid_we=0, ifid_flush=1, idex_flush=1.
- Reset asserted mid-DRAIN or in HALTED returns to RUN on the next edge. There is no residual state.
- The following definitions are used below:
  - luse = ex_mem_read && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd))
  - hlt = (id_instr==HALT_INSTR)
- RUN priority, highest first:
  1. ex_redirect: pc_sel=1, pc_we=1, ifid_we=1, ifid_flush=1, idex_flush=1. flush_cnt++. luse and hlt are ignored (the ID instruction is wrong-path).
  2. luse: pc_we=0, ifid_we=0, idex_flush=1, ifid_flush=0. stall_cnt++. Exactly one bubble per load, because the hazard clears once the load reaches MEM.
  3. hlt: pc_we=0, ifid_we=0, idex_flush=1 (halt itself never enters EX). drain <= DRAIN_CYCLES-1, state <= DRAIN.
  4. Otherwise: pc_we=1, ifid_we=1, pc_sel=0, no flushes.
- DRAIN: pc_we=0, ifid_we=0, idex_flush=1. ex_redirect cannot occur because EX holds a bubble or older non-branch work; if asserted it is ignored. Decrement drain; when drain==0, state <= HALTED and halted <= 1 on that edge.
- HALTED: pc_we=0, ifid_we=0, idex_flush=1, ifid_flush=0. Counters frozen.
- Counters:
  - cycle_cnt increments every non-reset cycle in RUN or DRAIN.
  - All counters saturate at all-ones; no wrap.
- ex_rd==0 never causes a stall. A load to x0 followed by a use of x0 runs without a bubble.

Decomposition:
- Shared package core_pkg holds:
  - state encoding (ST_RUN=2'd0, ST_DRAIN=2'd1, ST_HALTED=2'd2)
  - NOP_INSTR=32'h00000013
  - HALT_INSTR default
  - opcode constants
- One natural sub-module: sat_counter (CNT_W, inc, clear → q). It is instantiated three times.

Test Plan:
- Load-use: lw x3,2(x1) in EX (ex_mem_read=1, ex_rd=3), ID add x4,x3,x2 (id_rs1=3, use_rs1=1) → one cycle of pc_we=0, ifid_we=0, idex_flush=1; stall_cnt=1; the next cycle runs normally.
- No false stall: ex_mem_read=1, ex_rd=0, id_rs1=0 with use_rs1=1 → pc_we=1, no bubble; same with ex_rd=5 while use_rs1=0 and id_rs1=5 → no stall.
- Redirect beats stall: ex_redirect=1 with luse true in the same cycle → pc_sel=1, ifid_flush=1, idex_flush=1; flush_cnt=1, stall_cnt=0.
- Halt: id_instr=32'h00000063, no redirect → pc_we=0 from that cycle; halted rises exactly DRAIN_CYCLES=3 edges later; cycle_cnt then stops.
- Wrong-path halt: halt in ID with ex_redirect=1 → redirect taken, state stays RUN, halted stays 0.
- Reset mid-DRAIN and counter saturation: Reset=1 for one cycle during DRAIN → next cycle is RUN with counters 0. With CNT_W=4, 20 redirect cycles → flush_cnt holds at 4'hF.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core: sequencer state encoding and the
// instruction encodings the pipeline controls need to recognise.
package core_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [31:0] NOP_INSTR      = 32'h00000013;  // addi x0,x0,0
    localparam logic [31:0] HALT_INSTR_DEF = 32'h00000063;  // beq x0,x0,0

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of
// wrapping so long runs never report a misleadingly small count.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    logic [CNT_W-1:0] q_q;
    logic [CNT_W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (inc && (q_q != {CNT_W{1'b1}})) begin
            q_d = q_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (clear) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch/jump redirects,
// halt detection with drain-then-freeze, and performance counters.
module pipe_hazard_ctrl
    import core_pkg::*;
#(
    parameter int          CNT_W        = 32,
    parameter int          DRAIN_CYCLES = 3,
    parameter logic [31:0] HALT_INSTR   = HALT_INSTR_DEF
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [31:0]      id_instr,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    output logic             pc_we,
    output logic             pc_sel,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       dbg_state
);

    localparam int DW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

    state_t        state_q, state_d;
    logic [DW-1:0] drain_q, drain_d;
    logic          halted_q, halted_d;

    logic luse;
    logic hlt;
    logic cycle_inc;
    logic stall_inc;
    logic flush_inc;

    // x0 is hard-wired zero, so a load targeting it can never create a hazard.
    assign luse = ex_mem_read && (ex_rd != 5'd0) &&
                  ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                   (id_use_rs2 && (id_rs2 == ex_rd)));
    assign hlt  = (id_instr == HALT_INSTR);

    always_comb begin
        state_d    = state_q;
        drain_d    = drain_q;
        halted_d   = halted_q;
        pc_we      = 1'b0;
        pc_sel     = 1'b0;
        ifid_we    = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;

        if (Reset) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    // A redirect means the ID instruction is wrong-path, so it outranks stall and halt.
                    if (ex_redirect) begin
                        pc_we      = 1'b1;
                        pc_sel     = 1'b1;
                        ifid_we    = 1'b1;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        flush_inc  = 1'b1;
                    end else if (luse) begin
                        idex_flush = 1'b1;
                        stall_inc  = 1'b1;
                    end else if (hlt) begin
                        idex_flush = 1'b1;
                        drain_d    = DRAIN_LOAD;
                        state_d    = ST_DRAIN;
                    end else begin
                        pc_we   = 1'b1;
                        ifid_we = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    idex_flush = 1'b1;
                    if (drain_q == '0) begin
                        state_d  = ST_HALTED;
                        halted_d = 1'b1;
                    end else begin
                        drain_d = drain_q - DW'(1);
                    end
                end
                ST_HALTED: begin
                    idex_flush = 1'b1;
                end
                default: begin
                    idex_flush = 1'b1;
                    state_d    = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q  <= ST_RUN;
            drain_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            halted_q <= halted_d;
        end
    end

    assign cycle_inc = !Reset && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
    assign halted    = halted_q;
    assign dbg_state = state_q;

    sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
        .CLK   (CLK),
        .clear (Reset),
        .inc   (cycle_inc),
        .q     (cycle_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .clear (Reset),
        .inc   (stall_inc),
        .q     (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .CLK   (CLK),
        .clear (Reset),
        .inc   (flush_inc),
        .q     (flush_cnt)
    );

endmodule
